cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_array.sv | 56 +++++
 rtl/cache_controller.sv | 170 +++++++++++++++++
 tb/tb_cache_controller.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants for the direct-mapped write-through cache: address and
// block geometry, FSM state encoding and a word-select helper.
package cache_pkg;

    localparam int ADDR_W     = 12;
    localparam int BLOCK_BITS = 128;
    localparam int WORD_W     = 32;
    localparam int OFFSET_W   = 4;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_MISS = 2'd1;
    localparam logic [1:0] S_WR_THRU = 2'd2;

    // Word w of a block sits at bits [32w+31:32w], same layout as a refill.
    function automatic logic [WORD_W-1:0] word_of(input logic [BLOCK_BITS-1:0] blk,
                                                   input logic [1:0]            w);
        return blk[WORD_W*int'(w) +: WORD_W];
    endfunction

endpackage

// File: rtl/cache_array.sv
// Valid/tag/data storage for the cache: one combinational read port, one
// full-line write port (refill) and one word write port (store hit).
// Only the valid bits are reset; tag and data contents are don't-care until
// their valid bit is set.
module cache_array
    import cache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = ADDR_W - OFFSET_W - IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic                  o_rd_valid,
    output logic [TAG_W-1:0]      o_rd_tag,
    output logic [BLOCK_BITS-1:0] o_rd_data,
    input  logic                  i_line_we,
    input  logic [IDX_W-1:0]      i_line_idx,
    input  logic [TAG_W-1:0]      i_line_tag,
    input  logic [BLOCK_BITS-1:0] i_line_data,
    input  logic                  i_word_we,
    input  logic [IDX_W-1:0]      i_word_idx,
    input  logic [1:0]            i_word_sel,
    input  logic [WORD_W-1:0]     i_word_data
);

    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [BLOCK_BITS-1:0] r_data [LINES];

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

    // Valid bits: cleared by reset, set by a completed refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_line_we) begin
            r_valid[i_line_idx] <= 1'b1;
        end
    end

    // Tag/data storage, never reset; refill and store-hit never coincide.
    always_ff @(posedge clk) begin
        if (i_line_we) begin
            r_tag[i_line_idx]  <= i_line_tag;
            r_data[i_line_idx] <= i_line_data;
        end
        if (i_word_we) begin
            r_data[i_word_idx][WORD_W*int'(i_word_sel) +: WORD_W] <= i_word_data;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller with
// saturating hit/miss statistics. Block refill on read miss, single-word
// write-through on every store.
module cache_controller
    import cache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [WORD_W-1:0]     cpu_wdata,
    output logic [WORD_W-1:0]     cpu_rdata,
    output logic                  stall,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    input  logic                  mem_ready,
    input  logic [BLOCK_BITS-1:0] mem_rdata,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

    logic [1:0]          r_state;
    logic [ADDR_W-1:2]   r_addr;      // word address of the request in flight
    logic [WORD_W-1:0]   r_wdata;
    logic                r_done;      // write at r_addr already went through
    logic                r_refilled;  // line at r_addr was just refilled
    logic [CNT_W-1:0]    r_hit_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [1:0]            w_word;
    logic                  w_rd_valid;
    logic [TAG_W-1:0]      w_rd_tag;
    logic [BLOCK_BITS-1:0] w_rd_data;
    logic                  w_idle;
    logic                  w_hit;
    logic                  w_rd_req;
    logic                  w_wr_req;
    logic                  w_same;
    logic                  w_wr_done;
    logic                  w_rd_hit;
    logic                  w_rd_miss;
    logic                  w_wr_new;
    logic                  w_line_we;
    logic                  w_word_we;
    logic                  w_unused_addr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_idx         = cpu_addr[OFFSET_W +: IDX_W];
    assign w_tag         = cpu_addr[ADDR_W-1 -: TAG_W];
    assign w_word        = cpu_addr[3:2];
    assign w_unused_addr = ^cpu_addr[1:0];

    assign w_idle    = (r_state == S_IDLE);
    assign w_hit     = w_rd_valid && (w_rd_tag == w_tag);
    assign w_rd_req  = cpu_read & ~cpu_write;
    assign w_wr_req  = cpu_write & ~cpu_read;
    assign w_same    = (cpu_addr[ADDR_W-1:2] == r_addr);
    // A completed store stays "done" until the CPU drops or moves the request.
    assign w_wr_done = r_done & w_wr_req & w_same;
    assign w_rd_hit  = w_idle & w_rd_req & w_hit;
    assign w_rd_miss = w_idle & w_rd_req & ~w_hit;
    assign w_wr_new  = w_idle & w_wr_req & ~w_wr_done;

    assign w_line_we = mem_read & mem_ready;
    assign w_word_we = w_wr_new & w_hit & ~rst;

    cache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_rd_idx    (w_idx),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_data   (w_rd_data),
        .i_line_we   (w_line_we),
        .i_line_idx  (r_addr[OFFSET_W +: IDX_W]),
        .i_line_tag  (r_addr[ADDR_W-1 -: TAG_W]),
        .i_line_data (mem_rdata),
        .i_word_we   (w_word_we),
        .i_word_idx  (w_idx),
        .i_word_sel  (w_word),
        .i_word_data (cpu_wdata)
    );

    // Memory-side outputs decode the state only, so they drop with the return to IDLE.
    assign mem_read  = (r_state == S_RD_MISS);
    assign mem_write = (r_state == S_WR_THRU);
    assign mem_addr  = mem_read  ? {r_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}} :
                       mem_write ? {r_addr, 2'b00} : '0;
    assign mem_wdata = mem_write ? r_wdata : '0;

    assign stall      = ~rst & (~w_idle | w_rd_miss | w_wr_new);
    assign cpu_rdata  = w_rd_hit ? word_of(w_rd_data, w_word) : '0;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

    // Control FSM and request latches; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_done     <= 1'b0;
            r_refilled <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_refilled <= 1'b0;
                    if (!w_wr_done) begin
                        r_done <= 1'b0;
                    end
                    if (w_rd_miss) begin
                        r_addr  <= cpu_addr[ADDR_W-1:2];
                        r_state <= S_RD_MISS;
                    end else if (w_wr_new) begin
                        r_addr  <= cpu_addr[ADDR_W-1:2];
                        r_wdata <= cpu_wdata;
                        r_state <= S_WR_THRU;
                    end
                end
                S_RD_MISS: begin
                    if (mem_ready) begin
                        r_refilled <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                S_WR_THRU: begin
                    if (mem_ready) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Statistics: each request counts once; the replay after a refill is not a new hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if ((w_rd_hit && !(r_refilled && w_same)) || (w_wr_new && w_hit)) begin
                r_hit_cnt <= sat_inc(r_hit_cnt);
            end
            if (w_rd_miss || (w_wr_new && !w_hit)) begin
                r_miss_cnt <= sat_inc(r_miss_cnt);
            end
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a transaction-level cache/memory
// model predicts stall length, memory traffic, load data and statistics;
// one negedge process checks the memory-side outputs every cycle.
module tb_cache_controller;

    localparam int LINES = 32;
    localparam int CNT_W = 4;
    localparam int LAT   = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_read, cpu_write;
    logic [11:0]  cpu_addr;
    logic [31:0]  cpu_wdata, cpu_rdata;
    logic         stall, mem_read, mem_write, mem_ready;
    logic [11:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [127:0] mem_rdata;
    logic [CNT_W-1:0] hit_count, miss_count;

    always #5 clk = ~clk;

    cache_controller #(.LINES(LINES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- main memory model ----------------
    logic [31:0] mem_store [int];
    int force_req = 0;

    function automatic logic [31:0] mem_word(input int a);
        if (mem_store.exists(a)) return mem_store[a];
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    initial begin
        int cnt;
        int force_seen;
        cnt = 0;
        force_seen = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_ready || !(mem_read || mem_write)) begin
                cnt = 0;
                mem_ready = 1'b0;
                mem_rdata = '0;
            end else begin
                cnt++;
                if (cnt > LAT) begin
                    cnt = 0;
                    mem_ready = 1'b1;
                    if (mem_read) begin
                        for (int w = 0; w < 4; w++)
                            mem_rdata[32*w +: 32] = mem_word(int'(mem_addr) + 4*w);
                    end else begin
                        mem_store[int'(mem_addr)] = mem_wdata;
                    end
                end
            end
            if (force_req != force_seen) begin
                force_seen = force_req;
                mem_ready  = 1'b1;
                mem_rdata  = '1;
            end
        end
    end

    // ---------------- cache model ----------------
    bit          m_valid [LINES];
    int          m_tag   [LINES];
    logic [31:0] m_data  [LINES][4];
    int          m_hits, m_miss;

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
    endtask

    // ---------------- expectations for the memory side ----------------
    int          exp_kind = 0;   // 0 none, 1 block read, 2 word write
    int          exp_maddr = 0;
    logic [31:0] exp_mwdata = '0;
    int          rd_total = 0, wr_total = 0;
    logic [11:0] seen_maddr = '0;
    logic [31:0] seen_mwdata = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("reset_quiet", {29'd0, mem_read, mem_write, stall}, 32'd0);
            end else begin
                check("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
                if (mem_read) begin
                    rd_total++;
                    seen_maddr = mem_addr;
                    check("mem_read_expected", exp_kind, 1);
                    check("mem_read_addr", {20'd0, mem_addr}, exp_maddr);
                end else if (mem_write) begin
                    wr_total++;
                    seen_maddr  = mem_addr;
                    seen_mwdata = mem_wdata;
                    check("mem_write_expected", exp_kind, 2);
                    check("mem_write_addr", {20'd0, mem_addr}, exp_maddr);
                    check("mem_write_data", mem_wdata, exp_mwdata);
                end else begin
                    check("idle_mem_addr", {20'd0, mem_addr}, 32'd0);
                    check("idle_mem_wdata", mem_wdata, 32'd0);
                end
            end
        end
    end

    // ---------------- transaction driver ----------------
    int          last_stall;
    logic [31:0] last_rdata;
    int          last_rd, last_wr;

    task automatic access(input bit rd, input bit wr, input int addr, input logic [31:0] wd);
        int idx, tg, w, exp_stall, rd0, wr0;
        bit hit, timeout;
        logic [31:0] exp_rd;
        idx = (addr / 16) % LINES;
        tg  = addr / (16 * LINES);
        w   = (addr / 4) % 4;
        hit = m_valid[idx] && (m_tag[idx] == tg);
        @(posedge clk); #1;
        if (rd && !wr) begin
            exp_kind  = hit ? 0 : 1;
            exp_maddr = addr & ~15;
        end else if (wr && !rd) begin
            exp_kind   = 2;
            exp_maddr  = addr & ~3;
            exp_mwdata = wd;
        end else begin
            exp_kind = 0;
        end
        exp_stall = (exp_kind == 0) ? 0 : LAT + 2;
        rd0 = rd_total;
        wr0 = wr_total;
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = 12'(addr);
        cpu_wdata = wd;
        last_stall = 0;
        timeout = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!stall) begin
                timeout = 1'b0;
                break;
            end
            last_stall++;
            @(posedge clk); #1;
        end
        check("stall_bound", {31'd0, timeout}, 32'd0);
        last_rdata = cpu_rdata;
        // update the model with what this request must have done
        if (rd && !wr) begin
            if (!hit) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                for (int k = 0; k < 4; k++) m_data[idx][k] = mem_word((addr & ~15) + 4*k);
                m_miss = sat_inc(m_miss);
            end else begin
                m_hits = sat_inc(m_hits);
            end
            exp_rd = m_data[idx][w];
            check("cpu_rdata", cpu_rdata, exp_rd);
        end else if (wr && !rd) begin
            if (hit) begin
                m_data[idx][w] = wd;
                m_hits = sat_inc(m_hits);
            end else begin
                m_miss = sat_inc(m_miss);
            end
        end
        check("stall_cycles", last_stall, exp_stall);
        @(posedge clk); #1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        exp_kind = 0;
        @(negedge clk);
        last_rd = rd_total - rd0;
        last_wr = wr_total - wr0;
        check("mem_read_cycles", last_rd, (rd && !wr && !hit) ? LAT + 1 : 0);
        check("mem_write_cycles", last_wr, (wr && !rd) ? LAT + 1 : 0);
        check("hit_count", {28'd0, hit_count}, m_hits);
        check("miss_count", {28'd0, miss_count}, m_miss);
    endtask

    // Hold a load that hits for n cycles; every held cycle is a counted hit.
    task automatic hold_read(input int addr, input int n);
        int idx, w;
        idx = (addr / 16) % LINES;
        w   = (addr / 4) % 4;
        @(posedge clk); #1;
        exp_kind = 0;
        cpu_read = 1'b1;
        cpu_addr = 12'(addr);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check("hold_stall", {31'd0, stall}, 32'd0);
            check("hold_rdata", cpu_rdata, m_data[idx][w]);
            m_hits = sat_inc(m_hits);
            @(posedge clk); #1;
        end
        cpu_read = 1'b0;
        cpu_addr = '0;
        @(negedge clk);
        check("hold_hit_count", {28'd0, hit_count}, m_hits);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_hit_count", {28'd0, hit_count}, 32'd0);
        check("rst_miss_count", {28'd0, miss_count}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_mem_req", {30'd0, mem_read, mem_write}, 32'd0);
        rst = 1'b0;

        // Cold read miss with refill, then the held request completes.
        access(1, 0, 'h104, '0);
        check("pin_miss_stall", last_stall, 6);
        check("pin_miss_rdata", last_rdata, 32'hC0DE_0104);
        check("pin_miss_maddr", {20'd0, seen_maddr}, 32'h100);
        check("pin_miss_count", {28'd0, miss_count}, 32'd1);
        check("pin_miss_hits", {28'd0, hit_count}, 32'd0);

        // Same block, different word: pure hit.
        access(1, 0, 'h108, '0);
        check("pin_hit_stall", last_stall, 0);
        check("pin_hit_rdata", last_rdata, 32'hC0DE_0108);
        check("pin_hit_count", {28'd0, hit_count}, 32'd1);
        check("pin_hit_memrd", last_rd, 0);

        // Write hit goes through to memory and updates the line.
        access(0, 1, 'h108, 32'hDEAD_BEEF);
        check("pin_wr_maddr", {20'd0, seen_maddr}, 32'h108);
        check("pin_wr_mwdata", seen_mwdata, 32'hDEAD_BEEF);
        access(1, 0, 'h108, '0);
        check("pin_wr_readback", last_rdata, 32'hDEAD_BEEF);
        check("pin_wr_readback_stall", last_stall, 0);

        // Write miss: memory updated, no allocation.
        access(0, 1, 'h500, 32'h1234_5678);
        access(1, 0, 'h500, '0);
        check("pin_nwa_stall", last_stall, 6);
        check("pin_nwa_rdata", last_rdata, 32'h1234_5678);
        check("pin_nwa_miss", {28'd0, miss_count}, 32'd3);

        // Simultaneous read and write is ignored.
        access(1, 1, 'h104, 32'hFFFF_FFFF);

        // Stray mem_ready while idle must not touch anything.
        @(posedge clk); #1;
        force_req++;
        repeat (3) begin
            @(negedge clk);
            check("stray_stall", {31'd0, stall}, 32'd0);
        end
        access(1, 0, 'h500, '0);
        check("pin_stray_rdata", last_rdata, 32'h1234_5678);
        check("pin_stray_stall", last_stall, 0);

        // Alias: same index, different tags evict each other.
        access(1, 0, 'h100, '0);
        check("pin_alias1", last_stall, 6);
        access(1, 0, 'h300, '0);
        check("pin_alias2", last_stall, 6);
        access(1, 0, 'h100, '0);
        check("pin_alias3", last_stall, 6);

        // Saturating hit counter.
        hold_read('h100, 20);
        check("pin_hit_sat", {28'd0, hit_count}, CMAX);

        // Reset two cycles into a refill abandons it.
        @(posedge clk); #1;
        exp_kind  = 1;
        exp_maddr = 'h700;
        cpu_read  = 1'b1;
        cpu_addr  = 12'h700;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("pin_pre_rst_memrd", {31'd0, mem_read}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_drop_memrd", {31'd0, mem_read}, 32'd0);
        check("rst_drop_stall", {31'd0, stall}, 32'd0);
        model_reset();
        cpu_read = 1'b0;
        cpu_addr = '0;
        exp_kind = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        access(1, 0, 'h700, '0);
        check("pin_rst_reread_stall", last_stall, 6);
        check("pin_rst_reread_miss", {28'd0, miss_count}, 32'd1);
        check("pin_rst_reread_hits", {28'd0, hit_count}, 32'd0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
